// File: rtl/fir_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fir_feeder: sample FIFO + frame launcher for the nibble-serial FIR chain.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fir_feeder #(
  parameter int DEPTH  = 4,
  parameter int PERIOD = 4
) (
  input  logic                     clk,
  input  logic                     nReset,
  input  logic [7:0]               din_x,
  input  logic [15:0]              din_y,
  input  logic                     din_vld,
  output logic                     din_rdy,
  output logic                     Rdy,
  output logic [3:0]               Xout,
  output logic [3:0]               Yout,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = $clog2(PERIOD);
  localparam logic [GW-1:0] G_RELOAD = GW'(PERIOD - 1);
  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);

  logic [23:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [GW-1:0] gap;
  logic [7:0]    x_sr;
  logic [15:0]   y_sr;
  logic [1:0]    nib;
  logic          active;

  logic          full;
  logic          empty;
  logic          push;
  logic          launch;
  logic [23:0]   head;

  assign full    = (count == FULL_LVL);
  assign empty   = (count == '0);
  assign push    = din_vld & ~full;
  assign launch  = (gap == '0) & ~empty;
  assign head    = mem[rd_ptr];

  assign din_rdy = ~full;
  assign Rdy     = launch;
  assign level   = count;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {din_y, din_x};
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (launch) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, launch})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Gap counter enforces the minimum spacing between launches.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      gap <= '0;
    end else if (launch) begin
      gap <= G_RELOAD;
    end else if (gap != '0) begin
      gap <= gap - GW'(1);
    end
  end

  // Nibble 0 is emitted straight from the FIFO head; the shift registers
  // hold the remaining nibbles, with zeros shifted in behind X.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      Xout   <= '0;
      Yout   <= '0;
      x_sr   <= '0;
      y_sr   <= '0;
      nib    <= '0;
      active <= 1'b0;
    end else if (launch) begin
      Xout   <= head[3:0];
      Yout   <= head[11:8];
      x_sr   <= {4'h0, head[7:4]};
      y_sr   <= {4'h0, head[23:12]};
      nib    <= 2'd1;
      active <= 1'b1;
    end else if (active) begin
      Xout   <= x_sr[3:0];
      Yout   <= y_sr[3:0];
      x_sr   <= x_sr >> 4;
      y_sr   <= y_sr >> 4;
      nib    <= nib + 2'd1;
      if (nib == 2'd3) begin
        active <= 1'b0;
      end
    end else begin
      Xout   <= '0;
      Yout   <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fir_feeder: randomized and directed checks of fir_feeder vs a model.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_fir_feeder;

  localparam int DEPTH  = 4;
  localparam int PERIOD = 4;

  logic        clk     = 1'b0;
  logic        nReset  = 1'b0;
  logic [7:0]  din_x   = '0;
  logic [15:0] din_y   = '0;
  logic        din_vld = 1'b0;
  logic        din_rdy, Rdy;
  logic [3:0]  Xout, Yout;
  logic [2:0]  level;
  logic        din_rdy6, Rdy6;
  logic [3:0]  Xout6, Yout6;
  logic [2:0]  level6;

  fir_feeder #(.DEPTH(DEPTH), .PERIOD(PERIOD)) dut (
    .clk(clk), .nReset(nReset), .din_x(din_x), .din_y(din_y), .din_vld(din_vld),
    .din_rdy(din_rdy), .Rdy(Rdy), .Xout(Xout), .Yout(Yout), .level(level));

  fir_feeder #(.DEPTH(DEPTH), .PERIOD(6)) dut6 (
    .clk(clk), .nReset(nReset), .din_x(din_x), .din_y(din_y), .din_vld(din_vld),
    .din_rdy(din_rdy6), .Rdy(Rdy6), .Xout(Xout6), .Yout(Yout6), .level(level6));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @t=%0t: got %0h, want %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: a queue of pending samples plus a list of launched frames.
  typedef struct {
    int          c;
    logic [23:0] w;
  } launch_t;

  logic [23:0] mq[$];
  launch_t     lq[$];
  int          last_l = -1000;
  int          e_rdy, e_x, e_y, d;
  bit          mfull;

  always @(negedge clk) begin
    cyc++;
    if (!nReset) begin
      chk("rst_rdy", Rdy, 0);
      chk("rst_x", Xout, 0);
      chk("rst_y", Yout, 0);
      chk("rst_level", level, 0);
      chk("rst_din_rdy", din_rdy, 1);
      mq.delete();
      lq.delete();
      last_l = -1000;
    end else begin
      e_rdy = (mq.size() > 0 && (cyc - last_l) >= PERIOD) ? 1 : 0;
      e_x = 0;
      e_y = 0;
      foreach (lq[i]) begin
        d = cyc - lq[i].c;
        if (d >= 1 && d <= 4) begin
          e_y = int'((lq[i].w >> (8 + 4 * (d - 1))) & 24'hF);
          e_x = (d <= 2) ? int'((lq[i].w >> (4 * (d - 1))) & 24'hF) : 0;
        end
      end
      chk("rdy", Rdy, e_rdy);
      chk("xout", Xout, e_x);
      chk("yout", Yout, e_y);
      chk("level", level, mq.size());
      chk("din_rdy", din_rdy, (mq.size() < DEPTH) ? 1 : 0);
      mfull = (mq.size() == DEPTH);
      if (e_rdy == 1) begin
        lq.push_back('{cyc, mq[0]});
        mq.delete(0);
        last_l = cyc;
      end
      if (din_vld && !mfull) mq.push_back({din_y, din_x});
      while (lq.size() > 0 && (cyc - lq[0].c) > 5) lq.delete(0);
    end
  end

  task automatic idle(input int n);
    din_vld = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int exp_sx[4] = '{5, 10, 0, 0};
  int exp_sy[4] = '{4, 3, 2, 1};
  int exp_by[12] = '{4, 3, 2, 1, 8, 7, 6, 5, 12, 11, 10, 9};
  logic [15:0] b2b_y[3] = '{16'h1234, 16'h5678, 16'h9ABC};

  initial begin
    int          maxlvl;
    int          ph;
    int          idx;
    bit          saw_full;
    logic [3:0]  xlo;
    logic [7:0]  bpx[8];
    logic [7:0]  got[$];
    int          pct;

    nReset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_level", level, 0);
    chk("init_din_rdy", din_rdy, 1);
    chk("init_rdy", Rdy, 0);
    nReset = 1'b1;
    idle(3);

    // Single sample
    din_vld = 1'b1; din_x = 8'hA5; din_y = 16'h1234;
    @(posedge clk); #1;
    din_vld = 1'b0;
    chk("single_rdy", Rdy, 1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("single_x", Xout, exp_sx[i]);
      chk("single_y", Yout, exp_sy[i]);
    end
    @(posedge clk); #1;
    chk("single_x_tail", Xout, 0);
    chk("single_y_tail", Yout, 0);
    idle(12);

    // PERIOD=6 instance: two samples on consecutive edges
    din_vld = 1'b1; din_x = 8'h3C; din_y = 16'hBEEF;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        din_x = 8'h7E; din_y = 16'hCAFE;
      end else begin
        din_vld = 1'b0;
      end
      chk("p6_rdy", Rdy6, (c == 1 || c == 7) ? 1 : 0);
      if (c == 6 || c == 7) begin
        chk("p6_x_gap", Xout6, 0);
        chk("p6_y_gap", Yout6, 0);
      end
    end
    idle(12);

    // Back-to-back, three samples
    maxlvl = 0;
    din_vld = 1'b1; din_x = 8'h11; din_y = b2b_y[0];
    for (int c = 1; c <= 13; c++) begin
      @(posedge clk); #1;
      if (c <= 2) begin
        din_x = 8'h11 + 8'(c); din_y = b2b_y[c];
      end else begin
        din_vld = 1'b0;
      end
      chk("b2b_rdy", Rdy, (c == 1 || c == 5 || c == 9) ? 1 : 0);
      if (c >= 2) chk("b2b_y", Yout, exp_by[c - 2]);
      if (int'(level) > maxlvl) maxlvl = int'(level);
    end
    chk("b2b_peak_level", maxlvl, 2);
    idle(12);

    // Backpressure: eight distinct words pushed through a valid/ready handshake
    for (int i = 0; i < 8; i++) bpx[i] = 8'h31 + 8'(8'h13 * i);
    ph = 0; idx = 0; saw_full = 1'b0; xlo = '0;
    din_vld = 1'b1; din_x = bpx[0]; din_y = 16'h0F0F;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (level == 3'd4 && !din_rdy) saw_full = 1'b1;
      if (din_vld && din_rdy) idx++;
      @(posedge clk); #1;
      if (ph == 1) xlo = Xout;
      if (ph == 2) got.push_back({Xout, xlo});
      ph = Rdy ? 1 : ((ph > 0) ? ph + 1 : 0);
      din_vld = (idx < 8);
      if (idx < 8) begin
        din_x = bpx[idx]; din_y = 16'(idx * 16'h1111);
      end
    end
    chk("bp_saw_full", saw_full, 1);
    chk("bp_count", got.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < got.size()) chk("bp_order", got[i], bpx[i]);
    end
    idle(12);

    // Asynchronous reset during nibble 2 with two words queued
    din_vld = 1'b1; din_x = 8'hC3; din_y = 16'h4321;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      if (c <= 2) begin
        din_x = 8'hC3 + 8'(c); din_y = 16'h4321 + 16'(c);
      end else begin
        din_vld = 1'b0;
      end
    end
    chk("mr_level_pre", level, 2);
    #1;
    nReset = 1'b0;
    #1;
    chk("mr_rdy", Rdy, 0);
    chk("mr_x", Xout, 0);
    chk("mr_y", Yout, 0);
    chk("mr_level", level, 0);
    chk("mr_din_rdy", din_rdy, 1);
    @(posedge clk); #1;
    nReset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("mr_no_rdy", Rdy, 0);
    end

    // Randomized traffic at several offered loads
    for (int c = 0; c < 600; c++) begin
      pct = (c < 200) ? 20 : ((c < 400) ? 50 : 90);
      din_vld = ($urandom_range(0, 99) < pct);
      din_x   = 8'($urandom);
      din_y   = 16'($urandom);
      @(posedge clk); #1;
    end
    idle(30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fir_feeder.md
# fir_feeder

Upstream input stage for the nibble-serial FIR processing-element chain. Accepts parallel samples (8-bit X plus 16-bit Y seed) over a valid/ready handshake and buffers them in a small FIFO. Launches one frame per sample: a single-cycle Rdy strobe followed by nibble-serial X and Y streams, timed to match the first PE's load window. Enforces the minimum inter-frame spacing, so the chain never sees overlapping frames.

## Interface

- DEPTH, 4: FIFO entries; power of two, at least 2.
- PERIOD, 4: minimum cycles between successive Rdy strobes; at least 4.
- clk  in  1  rising-edge clock.
- nReset  in  1  asynchronous, active-low reset.
- din_x  in  8  sample X, unsigned.
- din_y  in  16  Y seed (partial sum entering the chain; 0 for a plain FIR).
- din_vld  in  1  din_x/din_y valid.
- din_rdy  out  1  FIFO can accept; transfer occurs on a clk edge with din_vld & din_rdy.
- Rdy  out  1  frame-start strobe to the first PE's Rdy.
- Xout  out  4  X nibble stream to the first PE's Xin.
- Yout  out  4  Y nibble stream to the first PE's Yin.
- level  out  clog2(DEPTH)+1  current FIFO occupancy.

## Operation

- Reset state (nReset low, asynchronous):
  - FIFO empty, so level=0 and din_rdy=1.
  - Rdy=0, Xout=0, Yout=0.
  - gap counter=0, shift registers cleared.
- FIFO:
  - 24-bit entries {din_y, din_x}, circular read/write pointers.
  - din_rdy = !full, from registered state only.
  - No push while full, even if a pop occurs the same cycle.
  - Push and pop in the same cycle when neither full nor empty: level unchanged.
  - No bypass: a word pushed at edge t is poppable from cycle t+1.
- Gap counter g:
  - Rdy = (g==0) & !empty, from registered state only, so it is glitch-free.
  - In a cycle with Rdy=1:
    - pop the head entry;
    - load the X shift register with din_x and the Y shift register with din_y at the closing edge;
    - load g with PERIOD-1.
  - Otherwise g decrements when nonzero, and holds at 0 when zero.
- States, derived from g and the nibble index:
  - IDLE: empty and no frame in flight.
  - LAUNCH: Rdy cycle.
  - SEND: nibble cycles 1..4.
  - WAIT: g>0 after nibble 4, which happens only when PERIOD>4.
  - LAUNCH of frame n+1 may coincide with SEND nibble 4 of frame n.
- Nibble sequence, for a frame launched (Rdy=1) in cycle k:
  - Cycle k+1: Xout=x[3:0], Yout=y[3:0].
  - Cycle k+2: Xout=x[7:4], Yout=y[7:4].
  - Cycle k+3: Xout=0, Yout=y[11:8].
  - Cycle k+4: Xout=0, Yout=y[15:12].
  - Outside these windows, Xout and Yout are driven 0 (never X).
  - A 2-bit nibble index plus an active flag selects the nibble.
- Reset mid-frame: the frame is abandoned immediately. FIFO contents are discarded and all outputs return to 0 asynchronously.
- The block has no knowledge of Cin or the PE arithmetic; coefficients are wired to the PEs directly.

## Timing

- Accept-to-launch: a word accepted at edge t into an empty, idle FIFO produces Rdy=1 in cycle t+1. Its first nibble appears in cycle t+2, and the PE Vld appears at t+6.
- Frame spacing:
  - Rdy pulses are exactly one cycle wide.
  - Consecutive Rdy strobes are separated by exactly PERIOD cycles while the FIFO stays non-empty.
  - A gap occurs only when the FIFO is empty.
- Throughput: one sample per PERIOD cycles. With PERIOD=4, Yout carries a nibble on every cycle of back-to-back frames.
- Full FIFO: din_rdy=0 from the cycle after level reaches DEPTH. It returns to 1 the cycle after the first pop.
- All outputs except Rdy are registered. Rdy decodes registered state only.

## Test plan

- Reset then single sample: push x=0xA5, y=0x1234 at edge 0.
  - Rdy=1 in cycle 1.
  - Xout 5, A, 0, 0 in cycles 2..5.
  - Yout 4, 3, 2, 1 in cycles 2..5.
  - Outputs 0 from cycle 6.
- Back-to-back with PERIOD=4: push 3 samples on consecutive cycles.
  - Rdy in cycles 1, 5, 9 only.
  - Yout nibbles contiguous in cycles 2..13.
  - level peaks at 2.
- Full/backpressure with DEPTH=4: hold din_vld high with 8 distinct words.
  - din_rdy drops when level=4.
  - No word is lost or duplicated; the Xout sequence matches push order.
- PERIOD=6: push 2 samples together.
  - Rdy in cycles 1 and 7.
  - Outputs 0 in cycles 6..7 apart from Rdy.
- Asynchronous reset mid-frame: assert nReset during nibble 2 of a frame with 2 words queued.
  - Rdy, Xout and Yout read 0 within the same cycle.
  - level=0 and din_rdy=1.
  - No Rdy after release until a new push.
